mdr_mem_sequencer: RTL and testbench

Control sequencer for the memory access path: MAR load, MDR load (from bus or from Mdatain), memory read/write handshake, and MDR drive back onto the bus. It shares this path between two requesters, instruction fetch and data access, and sits between the control unit and the MAR/MDR registers and the memory port. All MDR/MAR strobes originate here, so the control unit issues one request and waits for a done pulse.

---
 rtl/mem_seq_pkg.sv | 25 ++
 rtl/mem_timeout_ctr.sv | 23 ++
 rtl/mdr_mem_sequencer.sv | 100 ++++++++++
 tb/tb_mdr_mem_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared state encoding, grant IDs and arbitration helper for the MDR/MAR memory sequencer.
package mem_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD_MAR = 3'd1,
      S_WR_LOAD  = 3'd2,
      S_MEM_WAIT = 3'd3,
      S_CAPTURE  = 3'd4,
      S_DRIVE    = 3'd5,
      S_FINISH   = 3'd6,
      S_ABORT    = 3'd7
   } state_t;

   localparam logic GRANT_FETCH = 1'b0;
   localparam logic GRANT_DATA  = 1'b1;

   localparam int DEFAULT_TIMEOUT_CYCLES = 16;

   // Alternating priority on contention, otherwise whoever is pending wins.
   function automatic logic pick_winner(input logic f, input logic d, input logic last);
      return (f && d) ? ~last : d;
   endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: MEM_WAIT cycle counter with clear priority and a terminal-count flag.
module mem_timeout_ctr #(
   parameter int TO_W  = 8,
   parameter int LIMIT = 16
) (
   input  logic clock,
   input  logic clear,
   input  logic inc,
   input  logic clr,
   output logic expired
);

   logic [TO_W-1:0] cnt_q, cnt_d;

   always_comb cnt_d = clr ? '0 : inc ? cnt_q + 1'b1 : cnt_q;

   always_ff @(posedge clock or negedge clear)
      if (!clear) cnt_q <= '0;
      else        cnt_q <= cnt_d;

   assign expired = (cnt_q == TO_W'(LIMIT - 1));

endmodule

// File: rtl/mdr_mem_sequencer.sv
// mdr_mem_sequencer: arbitrates fetch/data requesters and sequences MAR/MDR strobes and the memory handshake.
module mdr_mem_sequencer
   import mem_seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int TO_W           = 8
) (
   input  logic clock,
   input  logic clear,
   input  logic fetch_req,
   input  logic data_rd_req,
   input  logic data_wr_req,
   input  logic mem_ready,
   output logic mar_in,
   output logic mdr_enable,
   output logic mdr_read,
   output logic mdr_out,
   output logic mem_rd,
   output logic mem_wr,
   output logic grant_fetch,
   output logic grant_data,
   output logic fetch_done,
   output logic data_done,
   output logic err,
   output logic busy
);

   state_t state_q, state_d;
   logic   grant_q, grant_d;
   logic   last_q, last_d;
   logic   wr_q, wr_d;
   logic   to_inc, to_clr, expired;
   logic   data_req, winner, done;

   assign data_req = data_rd_req | data_wr_req;
   assign winner   = pick_winner(fetch_req, data_req, last_q);

   mem_timeout_ctr #(
      .TO_W (TO_W),
      .LIMIT(TIMEOUT_CYCLES)
   ) u_timeout (
      .clock  (clock),
      .clear  (clear),
      .inc    (to_inc),
      .clr    (to_clr),
      .expired(expired)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      wr_d    = wr_q;
      to_inc  = (state_q == S_MEM_WAIT) && !mem_ready && !expired;
      to_clr  = !to_inc;
      case (state_q)
         S_IDLE:
            if (fetch_req || data_req) begin
               grant_d = winner;
               last_d  = winner;
               wr_d    = (winner == GRANT_DATA) && data_wr_req;
               state_d = S_LOAD_MAR;
            end
         S_LOAD_MAR: state_d = wr_q ? S_WR_LOAD : S_MEM_WAIT;
         S_WR_LOAD:  state_d = S_MEM_WAIT;
         // A ready on the terminal-count cycle still completes normally.
         S_MEM_WAIT: state_d = mem_ready ? (wr_q ? S_FINISH : S_CAPTURE) : expired ? S_ABORT : S_MEM_WAIT;
         S_CAPTURE:  state_d = S_DRIVE;
         default:    state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear)
      if (!clear) begin
         state_q <= S_IDLE;
         grant_q <= GRANT_FETCH;
         last_q  <= GRANT_FETCH;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         wr_q    <= wr_d;
      end

   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DRIVE) || (state_q == S_FINISH) || (state_q == S_ABORT);
   assign mar_in      = (state_q == S_LOAD_MAR);
   assign mdr_enable  = (state_q == S_WR_LOAD) || (state_q == S_CAPTURE);
   assign mdr_read    = (state_q == S_CAPTURE);
   assign mdr_out     = (state_q == S_DRIVE);
   assign mem_rd      = (state_q == S_MEM_WAIT) && !wr_q;
   assign mem_wr      = (state_q == S_MEM_WAIT) && wr_q;
   assign grant_fetch = busy && (grant_q == GRANT_FETCH);
   assign grant_data  = busy && (grant_q == GRANT_DATA);
   assign fetch_done  = done && (grant_q == GRANT_FETCH);
   assign data_done   = done && (grant_q == GRANT_DATA);
   assign err         = (state_q == S_ABORT);

endmodule

// File: tb/tb_mdr_mem_sequencer.sv
// tb_mdr_mem_sequencer: randomized bench comparing every cycle of each transaction against a trace model.
module tb_mdr_mem_sequencer;

   localparam int T = 16;

   logic clock = 1'b0, clear = 1'b0;
   logic fetch_req = 1'b0, data_rd_req = 1'b0, data_wr_req = 1'b0, mem_ready = 1'b0;
   logic mar_in, mdr_enable, mdr_read, mdr_out, mem_rd, mem_wr;
   logic grant_fetch, grant_data, fetch_done, data_done, err, busy;
   logic [11:0] obs;

   int n_cmp = 0, n_err = 0;
   bit m_last = 1'b0;

   always #5 clock = ~clock;

   mdr_mem_sequencer #(.TIMEOUT_CYCLES(T), .TO_W(8)) dut (
      .clock(clock), .clear(clear), .fetch_req(fetch_req), .data_rd_req(data_rd_req),
      .data_wr_req(data_wr_req), .mem_ready(mem_ready), .mar_in(mar_in), .mdr_enable(mdr_enable),
      .mdr_read(mdr_read), .mdr_out(mdr_out), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .grant_fetch(grant_fetch), .grant_data(grant_data), .fetch_done(fetch_done),
      .data_done(data_done), .err(err), .busy(busy)
   );

   assign obs = {mar_in, mdr_enable, mdr_read, mdr_out, mem_rd, mem_wr,
                 grant_fetch, grant_data, fetch_done, data_done, err, busy};

   // Expected output vector for one busy cycle owned by requester g (0 fetch, 1 data).
   function automatic logic [11:0] vec(input bit mar, men, mrd, mout, rd, wr, g, dn, er);
      return {mar, men, mrd, mout, rd, wr, ~g, g, dn & ~g, dn & g, er, 1'b1};
   endfunction

   task automatic txn(input string name, input bit f, input bit rd, input bit wr, input int lat, input bit noise);
      logic [11:0] ex[$];
      bit rq[$];
      bit g, w, to;
      int n;
      g = (f && (rd || wr)) ? ~m_last : (rd || wr);
      m_last = g;
      w = g && wr;
      to = (lat >= T);
      n = to ? T : lat + 1;
      ex.push_back(vec(1, 0, 0, 0, 0, 0, g, 0, 0));
      rq.push_back(1'($urandom));
      if (w) begin
         ex.push_back(vec(0, 1, 0, 0, 0, 0, g, 0, 0));
         rq.push_back(1'($urandom));
      end
      for (int k = 0; k < n; k++) begin
         ex.push_back(vec(0, 0, 0, 0, !w, w, g, 0, 0));
         rq.push_back(!to && k == n - 1);
      end
      if (to) ex.push_back(vec(0, 0, 0, 0, 0, 0, g, 1, 1));
      else if (w) ex.push_back(vec(0, 0, 0, 0, 0, 0, g, 1, 0));
      else begin
         ex.push_back(vec(0, 1, 1, 0, 0, 0, g, 0, 0));
         ex.push_back(vec(0, 0, 0, 1, 0, 0, g, 1, 0));
      end
      while (rq.size() < ex.size()) rq.push_back(1'($urandom));
      fetch_req = f;
      data_rd_req = rd;
      data_wr_req = wr;
      mem_ready = 1'($urandom);
      @(posedge clock); #1;
      foreach (ex[i]) begin
         mem_ready = rq[i];
         if (noise) {fetch_req, data_rd_req, data_wr_req} = 3'($urandom);
         @(negedge clock);
         n_cmp++;
         if (obs !== ex[i]) begin
            n_err++;
            $display("FAIL %s step%0d: got %b expected %b", name, i, obs, ex[i]);
         end
         @(posedge clock); #1;
      end
      {fetch_req, data_rd_req, data_wr_req} = 3'b000;
      mem_ready = 1'($urandom);
      @(negedge clock);
      n_cmp++;
      if (obs !== 12'b0) begin
         n_err++;
         $display("FAIL %s idle_after: got %b expected %b", name, obs, 12'b0);
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      clear = 1'b0;
      {fetch_req, data_rd_req, data_wr_req, mem_ready} = 4'b0000;
      @(negedge clock);
      n_cmp++;
      if (obs !== 12'b0) begin
         n_err++;
         $display("FAIL reset_state: got %b expected %b", obs, 12'b0);
      end
      clear = 1'b1;
      m_last = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_cmp++;
      if (obs !== 12'b0) begin
         n_err++;
         $display("FAIL reset_initial: got %b expected %b", obs, 12'b0);
      end
      do_reset();
   endtask

   task automatic test_fetch_read();
      txn("fetch_read", 1, 0, 0, 0, 0);
   endtask

   task automatic test_write_wait();
      txn("write_wait3", 0, 0, 1, 2, 0);
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 4; i++) txn($sformatf("alternate%0d", i), 1, 1, 0, 0, 0);
   endtask

   task automatic test_timeout();
      txn("timeout_rd", 1, 0, 0, T + 3, 0);
      txn("ready_at_limit", 1, 0, 0, T - 1, 0);
      txn("timeout_wr", 0, 0, 1, T, 0);
   endtask

   task automatic test_rd_wr_both();
      txn("rd_wr_both", 0, 1, 1, 1, 0);
   endtask

   task automatic test_reset_mid();
      logic [11:0] mw;
      mw = vec(0, 0, 0, 0, 1, 0, 0, 0, 0);
      fetch_req = 1'b1;
      mem_ready = 1'b0;
      @(posedge clock); #1;
      fetch_req = 1'b0;
      @(posedge clock); #1;
      @(posedge clock); #2;
      n_cmp++;
      if (obs !== mw) begin
         n_err++;
         $display("FAIL mid_wait_state: got %b expected %b", obs, mw);
      end
      clear = 1'b0;
      #1;
      n_cmp++;
      if (obs !== 12'b0) begin
         n_err++;
         $display("FAIL async_clear: got %b expected %b", obs, 12'b0);
      end
      @(negedge clock);
      n_cmp++;
      if (obs !== 12'b0) begin
         n_err++;
         $display("FAIL clear_no_done: got %b expected %b", obs, 12'b0);
      end
      @(posedge clock); #3;
      clear = 1'b1;
      m_last = 1'b0;
      @(negedge clock);
      n_cmp++;
      if (obs !== 12'b0) begin
         n_err++;
         $display("FAIL post_clear_idle: got %b expected %b", obs, 12'b0);
      end
      txn("fetch_after_clear", 1, 0, 0, 0, 0);
   endtask

   task automatic test_random();
      bit f, rd, wr;
      for (int i = 0; i < 40; i++) begin
         {f, rd, wr} = 3'($urandom);
         if (!(f || rd || wr)) f = 1'b1;
         txn($sformatf("random%0d", i), f, rd, wr, int'($urandom_range(0, 20)), 1'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clock); #1;
            @(negedge clock);
            n_cmp++;
            if (obs !== 12'b0) begin
               n_err++;
               $display("FAIL random_gap%0d: got %b expected %b", i, obs, 12'b0);
            end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_fetch_read();
      test_write_wait();
      test_back_to_back();
      test_timeout();
      test_rd_wr_both();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
